// File: rtl/ysyx_24070016_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_24070016_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/ysyx_24070016_rr_arb2.sv
// Two-way round-robin pick; bit 0 = IFU, bit 1 = LSU, one-hot grant out.
module ysyx_24070016_rr_arb2
    import ysyx_24070016_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_gnt,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_valid;
        // On a tie the requester that did not win last time goes next.
        if (&i_valid) begin
            o_gnt = (i_last_gnt == REQ_LSU) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ysyx_24070016_mem_arbiter.sv
// Shares one memory port between IFU (id 0) and LSU (id 1), one transaction in flight.
// Optional watchdog: define YSYX_24070016_ARB_TIMEOUT_EN.
module ysyx_24070016_mem_arbiter
    import ysyx_24070016_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    input  logic                ifu_req_wen,
    input  logic [DATA_W-1:0]   ifu_req_wdata,
    input  logic [DATA_W/8-1:0] ifu_req_wmask,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rsp_rdata,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    input  logic                mem_rsp_err
);

    arb_state_t          r_state, w_state_nxt;
    logic                r_gnt_id, r_last_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;

    logic [1:0]          w_gnt;
    logic                w_accept, w_done, w_timeout, w_gnt_rsp_ready;
    logic                w_rsp_valid, w_rsp_err;
    logic [DATA_W-1:0]   w_rsp_rdata;

    ysyx_24070016_rr_arb2 u_rr (
        .i_valid    ({lsu_req_valid, ifu_req_valid}),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_gnt)
    );

    assign w_gnt_rsp_ready = (r_gnt_id == REQ_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

`ifdef YSYX_24070016_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_state != IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state != IDLE && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_timeout        = 1'b0;
`endif

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_done        = 1'b0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        w_rsp_valid   = 1'b0;
        w_rsp_err     = 1'b0;
        w_rsp_rdata   = '0;
        unique case (r_state)
            IDLE: begin
`ifdef YSYX_24070016_ARB_TIMEOUT_EN
                // Sink a late slave response left over from a timed-out transaction.
                mem_rsp_ready = !rst;
`endif
                if (!rst && (|w_gnt)) begin
                    ifu_req_ready = w_gnt[0];
                    lsu_req_ready = w_gnt[1];
                    w_accept      = 1'b1;
                    w_state_nxt   = REQ;
                end
            end
            REQ: begin
                if (w_timeout) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    if (w_gnt_rsp_ready) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (w_timeout) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    if (w_gnt_rsp_ready) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    mem_rsp_ready = w_gnt_rsp_ready;
                    w_rsp_valid   = mem_rsp_valid;
                    w_rsp_err     = mem_rsp_err;
                    w_rsp_rdata   = mem_rsp_rdata;
                    if (mem_rsp_valid && w_gnt_rsp_ready) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ifu_rsp_valid = w_rsp_valid && (r_gnt_id == REQ_IFU);
    assign ifu_rsp_err   = w_rsp_err   && (r_gnt_id == REQ_IFU);
    assign ifu_rsp_rdata = (r_gnt_id == REQ_IFU) ? w_rsp_rdata : '0;
    assign lsu_rsp_valid = w_rsp_valid && (r_gnt_id == REQ_LSU);
    assign lsu_rsp_err   = w_rsp_err   && (r_gnt_id == REQ_LSU);
    assign lsu_rsp_rdata = (r_gnt_id == REQ_LSU) ? w_rsp_rdata : '0;

    assign mem_req_addr  = r_addr;
    assign mem_req_wen   = r_wen;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wmask = r_wmask;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt_id   <= REQ_IFU;
            r_last_gnt <= REQ_LSU;
            r_addr     <= '0;
            r_wen      <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_gnt_id <= w_gnt[1];
                r_addr   <= w_gnt[1] ? lsu_req_addr  : ifu_req_addr;
                r_wen    <= w_gnt[1] ? lsu_req_wen   : ifu_req_wen;
                r_wdata  <= w_gnt[1] ? lsu_req_wdata : ifu_req_wdata;
                r_wmask  <= w_gnt[1] ? lsu_req_wmask : ifu_req_wmask;
            end
            if (w_done) r_last_gnt <= r_gnt_id;
        end
    end

endmodule
